ps2_keyboard_intr_src: RTL and testbench
========================================

Name: ps2_keyboard_intr_src

Overview:
- Upstream interrupt source for the CPU trap handler: receives PS/2 keyboard frames, validates them, and buffers scan codes in a small FIFO.
- Presents each code as a one-cycle keyboard_intr pulse with keyboard_data, but only while the trap handler is idle, so no keystroke is lost while an ISR is being entered.
- Sits between the board PS/2 pins and the trap handler's keyboard_intr / keyboard_data_in inputs.

Parameters:
FILTER_LEN, 8, consecutive identical synchronized samples required before the filtered ps2_clk level changes.
TIMEOUT_CYCLES, 100000, clk cycles without a ps2_clk falling edge mid-frame before the frame is aborted.
FIFO_DEPTH, 4, scan-code FIFO entries; must be a power of 2, at least 2.
HOLDOFF, 4, minimum idle cycles after a keyboard_intr pulse before the next pulse may issue.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
ps2_clk  in  1  raw PS/2 clock pin, asynchronous
ps2_data  in  1  raw PS/2 data pin, asynchronous
handler_idle  in  1  high when the trap handler is idle (no keyboard/gametick/stackoverflow hazard); sampled through a flop only
clr_status  in  1  synchronous clear of frame_err and overflow
keyboard_intr  out  1  one-cycle interrupt pulse (registered)
keyboard_data  out  8  scan code; valid in the pulse cycle, held until the next pulse (registered)
fifo_count  out  clog2(FIFO_DEPTH)+1  entries currently buffered
frame_err  out  1  sticky: parity, stop or timeout error seen
overflow  out  1  sticky: byte dropped because the FIFO was full

Behaviour:
- Reset values: keyboard_intr=0, keyboard_data=8'h00, fifo_count=0, frame_err=0, overflow=0. Receive FSM in IDLE; FIFO pointers 0; holdoff counter 0; ready_q=0; synchronizers set to 1.
- Input conditioning:
  - 2-flop synchronizer on ps2_clk and ps2_data.
  - Clock filter: filtered level flips only after FILTER_LEN consecutive equal synchronized samples.
  - fall = filtered level 1->0, a single-cycle strobe. All bit sampling uses the synchronized ps2_data on the fall cycle.
- Receive FSM (LSB first, 11-bit frame):
  - IDLE: on fall, if data=0 go to DATA with bit_cnt=0; if data=1 stay in IDLE with no error.
  - DATA: on fall, shift the bit in. Once bit_cnt reaches 7 (8 bits received), go to PARITY.
  - PARITY: on fall, capture the parity bit and go to STOP.
  - STOP: on fall, check stop=1 and odd parity (popcount(data)+parity is odd).
    - Pass: push the byte into the FIFO on the next cycle.
    - Fail: discard the byte, set frame_err.
    - Either way, go to IDLE.
- Timeout: in DATA/PARITY/STOP, a counter counts cycles since the last fall. When it reaches TIMEOUT_CYCLES: abort to IDLE, discard the partial byte, set frame_err. The counter is cleared on every fall and while in IDLE.
- FIFO:
  - Push with FIFO full: drop the byte, set overflow, FIFO contents unchanged.
  - Push and pop in the same cycle: both take effect, fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Dispatch:
  - ready_q <= handler_idle every cycle.
  - Issue when fifo_count!=0 and ready_q=1 and holdoff=0 and keyboard_intr=0.
  - On issue, next cycle: keyboard_intr=1, keyboard_data=FIFO head, pop, holdoff loaded with HOLDOFF.
  - holdoff decrements to 0 on each cycle it is nonzero.
  - Pulses are therefore spaced at least HOLDOFF+1 cycles apart.
  - No combinational path from handler_idle to any output.
- Sticky flags:
  - clr_status clears frame_err and overflow.
  - If clr_status coincides with a new error, the error wins (flag stays set).
- rst mid-frame or mid-dispatch: immediate return to reset values; the partial frame and all FIFO contents are lost.

Test Plan:
- Frame 0x1C, parity 0, stop 1, handler_idle=1 -> fifo_count goes 1 then 0; exactly one keyboard_intr pulse with keyboard_data=8'h1C; frame_err=0.
- Frame 0x1C with parity 1 -> no push, no pulse, frame_err=1; clr_status pulse -> frame_err=0.
- handler_idle=0, send 0x16,0x1E,0x26,0x25,0x2E -> fifo_count=4, overflow=1. Raise handler_idle -> four pulses carrying 16,1E,26,25 in order, each at least HOLDOFF+1 cycles apart; 0x2E never appears.
- Send start plus 3 data bits, then hold ps2_clk high for TIMEOUT_CYCLES+10 -> FSM in IDLE, frame_err=1. Next full frame 0xF0 (parity 1) -> pulse with data 8'hF0.
- 3-cycle low glitch on ps2_clk while idle, plus ps2_data=0 -> no state change; a following valid 0x45 frame (parity 0) is received correctly.
- Assert rst after the 5th data bit of a frame, then release -> all outputs at reset values; next frame 0x29 (parity 0) is received and dispatched normally.

Source files
------------

// File: rtl/ps2_keyboard_intr_src.sv
// PS/2 keyboard receiver feeding a scan-code FIFO. Codes are dispatched as
// one-cycle keyboard_intr pulses, only while the trap handler reports idle.
module ps2_keyboard_intr_src #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 4,
  parameter int HOLDOFF        = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          handler_idle,
  input  logic                          clr_status,
  output logic                          keyboard_intr,
  output logic [7:0]                    keyboard_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync, data_sync;
  logic          clk_s, data_s;
  logic          filt, filt_prev, fall;
  logic [FW-1:0] filt_cnt;
  logic [TW-1:0] to_cnt;
  state_t        state_q, state_d;
  logic [7:0]    sr;
  logic [2:0]    bit_cnt;
  logic          par_q, push_q;
  logic          shift_en, cap_par, frame_ok, frame_bad, timeout;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          ready_q, issue, push_drop;
  logic [HW-1:0] holdoff_cnt;

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];
  assign fall   = filt_prev & ~filt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      filt      <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      filt_prev <= filt;
      if (clk_s == filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt     <= clk_s;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign timeout = (state_q != IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES));

  always_comb begin
    state_d   = state_q;
    shift_en  = 1'b0;
    cap_par   = 1'b0;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    case (state_q)
      IDLE:   if (fall && !data_s) state_d = DATA;
      DATA:   if (fall) begin
                shift_en = 1'b1;
                if (bit_cnt == 3'd7) state_d = PARITY;
              end
      PARITY: if (fall) begin
                cap_par = 1'b1;
                state_d = STOP;
              end
      STOP:   if (fall) begin
                // Odd parity over the data byte plus the parity bit.
                if (data_s && ^{sr, par_q}) frame_ok = 1'b1;
                else frame_bad = 1'b1;
                state_d = IDLE;
              end
      default: state_d = IDLE;
    endcase
    if (timeout) begin
      state_d   = IDLE;
      frame_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      par_q   <= 1'b0;
      push_q  <= 1'b0;
      to_cnt  <= '0;
    end else begin
      state_q <= state_d;
      push_q  <= frame_ok;
      if (state_q == IDLE) bit_cnt <= '0;
      if (shift_en) begin
        sr      <= {data_s, sr[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (cap_par) par_q <= data_s;
      if (state_q == IDLE || fall) to_cnt <= '0;
      else if (to_cnt != TW'(TIMEOUT_CYCLES)) to_cnt <= to_cnt + 1'b1;
    end
  end

  assign issue     = (fifo_count != '0) && ready_q && (holdoff_cnt == '0) && !keyboard_intr;
  assign push_drop = push_q && (fifo_count == (AW+1)'(FIFO_DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr          <= '0;
      rptr          <= '0;
      fifo_count    <= '0;
      ready_q       <= 1'b0;
      holdoff_cnt   <= '0;
      keyboard_intr <= 1'b0;
      keyboard_data <= 8'h00;
      frame_err     <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      ready_q       <= handler_idle;
      keyboard_intr <= issue;
      if (push_q && !push_drop) begin
        mem[wptr] <= sr;
        wptr      <= wptr + 1'b1;
      end
      if (issue) begin
        keyboard_data <= mem[rptr];
        rptr          <= rptr + 1'b1;
        holdoff_cnt   <= HW'(HOLDOFF);
      end else if (holdoff_cnt != '0) begin
        holdoff_cnt <= holdoff_cnt - 1'b1;
      end
      fifo_count <= fifo_count + {{AW{1'b0}}, (push_q && !push_drop)} - {{AW{1'b0}}, issue};
      if (frame_bad)       frame_err <= 1'b1;
      else if (clr_status) frame_err <= 1'b0;
      if (push_drop)       overflow  <= 1'b1;
      else if (clr_status) overflow  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ps2_keyboard_intr_src.sv
// Directed bench for ps2_keyboard_intr_src: bit-banged PS/2 frames with
// hand-computed expected scan codes, flags and pulse spacing.
module tb_ps2_keyboard_intr_src;
  localparam int TO = 300;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       handler_idle = 1'b1;
  logic       clr_status = 1'b0;
  logic       keyboard_intr;
  logic [7:0] keyboard_data;
  logic [2:0] fifo_count;
  logic       frame_err;
  logic       overflow;

  int vectors = 0;
  int miscompares = 0;

  int         cyc = 0;
  int         pulse_cnt = 0;
  int         cnt1_cycles = 0;
  logic [7:0] pulse_dat [64];
  int         pulse_cyc [64];

  ps2_keyboard_intr_src #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(4), .HOLDOFF(4)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .handler_idle(handler_idle), .clr_status(clr_status),
    .keyboard_intr(keyboard_intr), .keyboard_data(keyboard_data),
    .fifo_count(fifo_count), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (fifo_count == 3'd1) cnt1_cycles <= cnt1_cycles + 1;
    if (keyboard_intr && pulse_cnt < 64) begin
      pulse_dat[pulse_cnt] <= keyboard_data;
      pulse_cyc[pulse_cnt] <= cyc;
      pulse_cnt <= pulse_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    cycles(10);
    ps2_clk = 1'b0;
    cycles(20);
    ps2_clk = 1'b1;
    cycles(10);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    cycles(20);
  endtask

  task automatic clr_pulse();
    clr_status = 1'b1;
    cycles(1);
    clr_status = 1'b0;
    cycles(1);
  endtask

  initial begin
    int base, c1;
    logic [7:0] codes [4];
    codes[0] = 8'h16; codes[1] = 8'h1E; codes[2] = 8'h26; codes[3] = 8'h25;

    cycles(3);
    chk("rst_intr", {31'd0, keyboard_intr}, 32'd0);
    chk("rst_data", {24'd0, keyboard_data}, 32'h00);
    chk("rst_count", {29'd0, fifo_count}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    cycles(5);

    // good frame 0x1C
    base = pulse_cnt; c1 = cnt1_cycles;
    send_frame(8'h1C, 1'b0);
    chk("t1_pulses", pulse_cnt - base, 1);
    chk("t1_data", {24'd0, pulse_dat[base]}, 32'h1C);
    chk("t1_count1_seen", {31'd0, cnt1_cycles > c1}, 1);
    chk("t1_count", {29'd0, fifo_count}, 0);
    chk("t1_ferr", {31'd0, frame_err}, 0);

    // bad parity
    base = pulse_cnt;
    send_frame(8'h1C, 1'b1);
    chk("t2_pulses", pulse_cnt - base, 0);
    chk("t2_count", {29'd0, fifo_count}, 0);
    chk("t2_ferr", {31'd0, frame_err}, 1);
    clr_pulse();
    chk("t2_ferr_clr", {31'd0, frame_err}, 0);

    // overflow while handler busy
    handler_idle = 1'b0;
    base = pulse_cnt;
    send_frame(8'h16, 1'b0);
    send_frame(8'h1E, 1'b1);
    send_frame(8'h26, 1'b0);
    send_frame(8'h25, 1'b0);
    send_frame(8'h2E, 1'b1);
    chk("t3_count", {29'd0, fifo_count}, 4);
    chk("t3_ovf", {31'd0, overflow}, 1);
    chk("t3_no_pulse", pulse_cnt - base, 0);
    handler_idle = 1'b1;
    cycles(60);
    chk("t3_pulses", pulse_cnt - base, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_data%0d", i), {24'd0, pulse_dat[base+i]}, {24'd0, codes[i]});
      if (i > 0) chk($sformatf("t3_gap%0d", i), {31'd0, (pulse_cyc[base+i] - pulse_cyc[base+i-1]) >= 5}, 1);
    end
    chk("t3_count_empty", {29'd0, fifo_count}, 0);
    clr_pulse();
    chk("t3_ovf_clr", {31'd0, overflow}, 0);

    // timeout mid-frame
    base = pulse_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    ps2_data = 1'b1;
    cycles(TO + 10);
    chk("t4_ferr", {31'd0, frame_err}, 1);
    chk("t4_no_pulse", pulse_cnt - base, 0);
    clr_pulse();
    send_frame(8'hF0, 1'b1);
    chk("t4_pulses", pulse_cnt - base, 1);
    chk("t4_data", {24'd0, pulse_dat[base]}, 32'hF0);
    chk("t4_ferr_after", {31'd0, frame_err}, 0);

    // glitch on ps2_clk is filtered out
    base = pulse_cnt;
    ps2_data = 1'b0;
    cycles(5);
    ps2_clk = 1'b0;
    cycles(3);
    ps2_clk = 1'b1;
    cycles(10);
    ps2_data = 1'b1;
    cycles(30);
    send_frame(8'h45, 1'b0);
    chk("t5_pulses", pulse_cnt - base, 1);
    chk("t5_data", {24'd0, pulse_dat[base]}, 32'h45);
    chk("t5_ferr", {31'd0, frame_err}, 0);

    // reset mid-frame
    send_frame(8'h00, 1'b0);
    chk("t6_pre_ferr", {31'd0, frame_err}, 1);
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(i[0]);
    rst = 1'b1;
    cycles(2);
    chk("t6_intr", {31'd0, keyboard_intr}, 0);
    chk("t6_data", {24'd0, keyboard_data}, 32'h00);
    chk("t6_count", {29'd0, fifo_count}, 0);
    chk("t6_ferr", {31'd0, frame_err}, 0);
    chk("t6_ovf", {31'd0, overflow}, 0);
    rst = 1'b0;
    ps2_data = 1'b1;
    cycles(40);
    base = pulse_cnt;
    send_frame(8'h29, 1'b0);
    chk("t6_pulses", pulse_cnt - base, 1);
    chk("t6_post_data", {24'd0, pulse_dat[base]}, 32'h29);
    chk("t6_post_ferr", {31'd0, frame_err}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
